// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU (C) has default priority,
// a saturating wait counter bounds debug-port (D) starvation, and d_lock gives D burst ownership.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 4,
  localparam int WW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          dbg_locked,
  output logic [WW-1:0] dbg_wait_cnt
);

  // Handshake: a port's req/we/addr/wdata are held until its gnt; gnt in the same
  // cycle means the access reaches memory this cycle; read data returns with
  // rvalid exactly one cycle later.

  typedef enum logic {SHARED = 1'b0, D_LOCK = 1'b1} state_t;

  localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          rd_pend;
  logic          rd_owner;

  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (state == D_LOCK) begin
        d_gnt = d_req;
      end else begin
        d_gnt = d_req & (~c_req | (wait_cnt >= MAX_W));
        c_gnt = c_req & ~d_gnt;
      end
    end
  end

  assign c_stall = rst & c_req & ~c_gnt;

  // Memory side is zero whenever nobody holds a grant.
  assign m_en    = c_gnt | d_gnt;
  assign m_we    = d_gnt ? d_we    : (c_gnt & c_we);
  assign m_addr  = d_gnt ? d_addr  : (c_gnt ? c_addr  : '0);
  assign m_wdata = d_gnt ? d_wdata : (c_gnt ? c_wdata : '0);

  assign c_rvalid = rd_pend & ~rd_owner;
  assign d_rvalid = rd_pend & rd_owner;
  assign c_rdata  = c_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

  assign dbg_locked   = (state == D_LOCK);
  assign dbg_wait_cnt = wait_cnt;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state    <= SHARED;
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend  <= m_en & ~m_we;
      rd_owner <= d_gnt;

      if (d_gnt | ~d_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt < MAX_W) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      // The cycle in which d_lock drops is still D-owned; SHARED resumes after it.
      case (state)
        SHARED:  if (d_gnt & d_lock) state <= D_LOCK;
        D_LOCK:  if (!d_lock)        state <= SHARED;
        default:                     state <= SHARED;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios, a contention vector table and
// randomized traffic, all checked every cycle against a reference model.
module tb_dmem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;
  localparam int WW       = $clog2(MAX_WAIT + 1);

  logic          CLK = 1'b0;
  logic          rst;
  logic          c_req, c_we, c_gnt, c_stall, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          dbg_locked;
  logic [WW-1:0] dbg_wait_cnt;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .dbg_locked(dbg_locked), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- memory array model ----------------
  logic [DW-1:0] mem [2**AW];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge CLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] exp_mem [2**AW];
  logic [DW:0]   exp_q[$];       // {owner_is_d, data} for reads awaiting return
  bit            ref_locked;
  int            ref_waits;
  bit            g_c, g_d;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Evaluate the cycle at the falling edge, when inputs and outputs are settled.
  task automatic settle();
    logic [DW:0]   e;
    logic          cv, dv, ewe;
    logic [DW-1:0] cd, dd, ewd;
    logic [AW-1:0] ea;
    @(negedge CLK);
    if (!rst) begin
      g_c = 0; g_d = 0;
      ref_locked = 0; ref_waits = 0;
      exp_q.delete();
    end else if (ref_locked) begin
      g_d = d_req; g_c = 0;
    end else begin
      g_d = d_req && (!c_req || ref_waits >= MAX_WAIT);
      g_c = c_req && !g_d;
    end
    ewe = g_d ? d_we    : (g_c ? c_we    : 1'b0);
    ea  = g_d ? d_addr  : (g_c ? c_addr  : '0);
    ewd = g_d ? d_wdata : (g_c ? c_wdata : '0);
    check("c_gnt", c_gnt, g_c);
    check("d_gnt", d_gnt, g_d);
    check("gnt_exclusive", c_gnt & d_gnt, 0);
    check("c_stall", c_stall, rst && c_req && !g_c);
    check("m_en", m_en, g_c || g_d);
    check("m_we", m_we, ewe);
    check("m_addr", m_addr, ea);
    check("m_wdata", m_wdata, ewd);
    cv = 0; dv = 0; cd = '0; dd = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[DW]) begin dv = 1; dd = e[DW-1:0]; end
      else       begin cv = 1; cd = e[DW-1:0]; end
    end
    check("c_rvalid", c_rvalid, cv);
    check("d_rvalid", d_rvalid, dv);
    check("c_rdata", c_rdata, cd);
    check("d_rdata", d_rdata, dd);
    check("locked", dbg_locked, ref_locked);
    check("wait_cnt", dbg_wait_cnt, ref_waits);
  endtask

  // Commit the cycle's effects into the model at the rising edge.
  task automatic advance();
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    @(posedge CLK);
    if (rst) begin
      if (g_c || g_d) begin
        we = g_d ? d_we : c_we;
        a  = g_d ? d_addr : c_addr;
        wd = g_d ? d_wdata : c_wdata;
        if (we) exp_mem[a] = wd;
        else    exp_q.push_back({g_d, exp_mem[a]});
      end
      if (d_req && !g_d) ref_waits = (ref_waits < MAX_WAIT) ? ref_waits + 1 : ref_waits;
      else               ref_waits = 0;
      ref_locked = ref_locked ? d_lock : (g_d && d_lock);
    end else begin
      ref_waits = 0;
      ref_locked = 0;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic c_set(input logic rq, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    c_req = rq; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic d_set(input logic rq, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_req = rq; d_we = we; d_lock = lk; d_addr = a; d_wdata = wd;
  endtask

  task automatic idle();
    c_set(0, 0, '0, '0);
    d_set(0, 0, 0, '0, '0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return AW'($urandom_range(0, 2**AW - 1));
    endcase
  endfunction

  // ---------------- contention vector table ----------------
  typedef struct {
    logic cr;
    logic dr;
    logic exp_cg;
    logic exp_dg;
    logic exp_stall;
  } vec_t;
  vec_t vecs [10];

  initial begin
    for (int i = 0; i < 10; i++) begin
      vecs[i].cr        = 1;
      vecs[i].dr        = 1;
      vecs[i].exp_cg    = (i % 5 != 4);
      vecs[i].exp_dg    = (i % 5 == 4);
      vecs[i].exp_stall = (i % 5 == 4);
    end

    // ---- reset and memory preload ----
    rst = 0;
    idle();
    for (int i = 0; i < 2**AW; i++) begin
      @(posedge CLK);
      #1;
      pl_en = 1;
      pl_addr = AW'(i);
      pl_data = (i == 0) ? DW'(30000) : DW'($urandom);
      exp_mem[i] = pl_data;
    end
    @(posedge CLK);
    #1;
    pl_en = 0;
    c_set(1, 0, 8'd9, '0);       // request during reset must not be granted
    d_set(1, 0, 1, 8'd9, '0);
    settle();
    check("rst_c_stall", c_stall, 0);
    advance();
    idle();
    rst = 1;
    settle();
    check("rst_locked", dbg_locked, 0);
    check("rst_wait", dbg_wait_cnt, 0);
    advance();

    // ---- C reads address 0 ----
    c_set(1, 0, 8'd0, '0);
    settle();
    check("s1_c_gnt", c_gnt, 1);
    advance();
    idle();
    settle();
    check("s1_c_rvalid", c_rvalid, 1);
    check("s1_c_rdata", c_rdata, 30000);
    check("s1_d_rvalid", d_rvalid, 0);
    advance();

    // ---- D writes 10 to address 1, then C reads it ----
    d_set(1, 1, 0, 8'd1, 16'd10);
    settle();
    check("s2_d_gnt", d_gnt, 1);
    advance();
    idle();
    c_set(1, 0, 8'd1, '0);
    settle();
    check("s2_no_d_rvalid", d_rvalid, 0);
    advance();
    idle();
    settle();
    check("s2_c_rdata", c_rdata, 10);
    advance();

    // ---- continuous contention: C,C,C,C,D repeating ----
    for (int i = 0; i < 10; i++) begin
      c_set(vecs[i].cr, 0, 8'd2, '0);
      d_set(vecs[i].dr, 0, 0, 8'd3, '0);
      settle();
      check("tbl_c_gnt", c_gnt, vecs[i].exp_cg);
      check("tbl_d_gnt", d_gnt, vecs[i].exp_dg);
      check("tbl_c_stall", c_stall, vecs[i].exp_stall);
      advance();
    end
    idle();
    settle();
    advance();

    // ---- D locked burst of 16 reads while C keeps requesting ----
    c_set(1, 0, 8'd5, '0);
    d_set(1, 0, 1, 8'd0, '0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      settle();
      check("prelock_c_gnt", c_gnt, 1);
      check("prelock_unlocked", dbg_locked, 0);
      advance();
    end
    for (int k = 0; k < 16; k++) begin
      d_set(1, 0, (k != 15), AW'(k), '0);
      settle();
      check("lock_c_gnt", c_gnt, 0);
      check("lock_c_stall", c_stall, 1);
      check("lock_d_gnt", d_gnt, 1);
      if (k > 0) begin
        check("lock_d_rvalid", d_rvalid, 1);
        check("lock_d_rdata", d_rdata, exp_mem[k-1]);
      end
      advance();
    end
    d_set(0, 0, 0, '0, '0);
    settle();
    check("unlock_c_gnt", c_gnt, 1);
    check("unlock_d_rdata", d_rdata, exp_mem[15]);
    advance();
    idle();
    settle();
    advance();

    // ---- reset asserted with a read in flight ----
    c_set(1, 0, 8'd7, '0);
    settle();
    advance();
    idle();
    rst = 0;
    settle();
    check("rst_rd_c_rvalid", c_rvalid, 0);
    check("rst_rd_m_en", m_en, 0);
    advance();
    rst = 1;
    settle();
    check("rst_rd_c_rvalid2", c_rvalid, 0);
    advance();

    // ---- reset asserted while locked ----
    d_set(1, 0, 1, 8'hff, '0);
    settle();
    advance();
    settle();
    check("midlock_locked", dbg_locked, 1);
    advance();
    rst = 0;
    settle();
    check("midlock_rst_unlocked", dbg_locked, 0);
    check("midlock_rst_d_gnt", d_gnt, 0);
    advance();
    idle();
    rst = 1;
    settle();
    check("midlock_rel_locked", dbg_locked, 0);
    check("midlock_rel_wait", dbg_wait_cnt, 0);
    advance();

    // ---- wrap-edge address passes through ----
    c_set(1, 1, 8'hff, 16'hbeef);
    settle();
    check("wrap_m_addr", m_addr, 8'hff);
    advance();
    idle();
    d_set(1, 0, 0, 8'hff, '0);
    settle();
    advance();
    idle();
    settle();
    check("wrap_d_rdata", d_rdata, 16'hbeef);
    advance();

    // ---- randomized traffic ----
    for (int n = 0; n < 3000; n++) begin
      if (!c_req || g_c || $urandom_range(0, 9) == 0)
        c_set($urandom_range(0, 3) != 0, $urandom_range(0, 1), rand_addr(), DW'($urandom));
      if (!d_req || g_d || $urandom_range(0, 9) == 0)
        d_set($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, rand_addr(), DW'($urandom));
      d_lock = ref_locked ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      rst = (n % 700 != 350);
      settle();
      advance();
    end
    rst = 1;
    idle();
    settle();
    advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter for the single-port data memory, shared between two requesters: the CPU memory stage (port C) and the host/debug port (port D). Port D loads data before a run, dumps memory after `do_halt`, and feeds the 7-segment readout. Port C has default priority; a wait counter bounds starvation of port D, and a lock lets port D own the memory for multi-word bursts. The block sits between the memory stage, the host logic and the data-memory array, and adds no latency to a granted access.

## Interface
Parameters:
- `AW`, 8: address width in words
- `DW`, 16: data width
- `MAX_WAIT`, 4: cycles port D may be denied before it is forced to win (0 = port D has strict priority)

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `c_req`, `c_we`  in  1  CPU access request and write enable
- `c_addr`  in  AW  CPU address
- `c_wdata`  in  DW  CPU write data
- `c_gnt`  out  1  CPU access accepted this cycle
- `c_stall`  out  1  `c_req & ~c_gnt`; freezes the CPU pipeline
- `c_rvalid`  out  1  CPU read data valid
- `c_rdata`  out  DW  CPU read data
- `d_req`, `d_we`, `d_lock`  in  1  debug request, write enable, burst lock
- `d_addr`  in  AW  debug address
- `d_wdata`  in  DW  debug write data
- `d_gnt`  out  1  debug access accepted this cycle
- `d_rvalid`  out  1  debug read data valid
- `d_rdata`  out  DW  debug read data
- `m_en`, `m_we`  out  1  memory enable and write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data; valid the cycle after a read enable

## Operation
- State machine `state`: SHARED, D_LOCK.
- SHARED: grant is combinational from the current inputs.
  - Port D wins if `d_req & (~c_req | wait_cnt >= MAX_WAIT)`.
  - Otherwise port C wins if `c_req`.
  - Never both `c_gnt` and `d_gnt` in the same cycle.
- `wait_cnt` (width clog2(MAX_WAIT+1), saturating):
  - increments when `d_req & ~d_gnt`
  - clears when `d_gnt` or `~d_req`
- SHARED -> D_LOCK: when `d_gnt & d_lock`.
- D_LOCK:
  - `c_gnt` = 0.
  - `d_gnt` = `d_req`.
  - Returns to SHARED on the first edge where `d_lock` = 0. That cycle is still D_LOCK-owned, and a `d_req` in it is granted.
- Memory mux:
  - `m_en` = `c_gnt | d_gnt`.
  - `m_we`, `m_addr` and `m_wdata` come from the granted port.
  - All four are 0 when there is no grant.
- Read return:
  - Registers `rd_pend` and `rd_owner` capture a granted read (`gnt & ~we`).
  - Next cycle, `rvalid` of that owner = 1 and its `rdata` = `m_rdata`.
  - The non-owner's `rdata` holds 0.
  - Writes produce no `rvalid`.
- Requesters hold `req`, `we`, `addr` and `wdata` stable until `gnt`. A request dropped before grant is legal; there is no side effect.
- Reset values of all outputs: `c_gnt`, `d_gnt`, `c_stall`, `c_rvalid`, `d_rvalid` = 0; `c_rdata`, `d_rdata` = 0; all `m_*` = 0.
- Reset values of state: `state` = SHARED, `wait_cnt` = 0.
- While `rst` = 0, all grants are forced to 0.

## Timing
- Grant latency is 0 cycles when uncontended: `gnt` is in the same cycle as `req`.
- Read data latency: `rvalid` exactly 1 cycle after `gnt`, for one cycle per granted read.
- Back-to-back reads from one port: one grant per cycle; `rvalid` streams at 1/cycle, delayed by 1.
- Simultaneous `c_req` and `d_req` with `wait_cnt < MAX_WAIT`:
  - C granted, D denied, `wait_cnt` increments.
  - On the (MAX_WAIT+1)-th contended cycle D is granted and C stalls for 1 cycle.
- `d_lock` asserted with `d_req` while C is winning: no lock is taken until D is actually granted.
- `rst` asserted mid-read: `rd_pend` is cleared asynchronously and the pending `rvalid` is never issued.
- `rst` asserted mid-lock: returns to SHARED.
- An address at the wrap edge (`2^AW-1`) passes through unchanged; the arbiter does no address arithmetic.

## Test plan
- Reset, then C reads address 0 preloaded with 30000: `c_gnt` = 1 in the same cycle; next cycle `c_rvalid` = 1 and `c_rdata` = 30000; `d_rvalid` stays 0.
- D writes 10 to address 1 with C idle, then C reads address 1: `d_gnt` immediately; no `d_rvalid`; C read returns 10.
- C and D both request continuously with MAX_WAIT = 4: grant sequence is C,C,C,C,D,C,C,C,C,D…; `c_stall` = 1 exactly on the D cycles.
- D locks and reads addresses 0..15 over 16 cycles while `c_req` = 1 throughout: `c_gnt` = 0 and `c_stall` = 1 for all 16 cycles; `d_rvalid` for 16 consecutive cycles with the matching data; C is granted on the cycle after `d_lock` falls.
- `rst` pulled low on the cycle after a C read grant: no `c_rvalid`; all outputs 0 during reset; `state` = SHARED and `wait_cnt` = 0 after release.
- Every cycle of every scenario: `c_gnt & d_gnt` never 1; `m_en == (c_gnt | d_gnt)`; `m_addr` and `m_wdata` match the granted port.
